reg_bank16: RTL and testbench

- Register storage stage directly upstream of the 16:1 32-bit read-select mux in the datapath.
- Holds 16 x 32-bit architectural registers and accepts write-back through a one-deep commit latch with a valid/ready handshake.
- Presents all registers on one flattened bus for the downstream read mux, with the in-flight write already bypassed onto that bus.
- Includes a sequenced bulk-clear engine.

---
 rtl/reg_bank_pkg.sv | 19 +
 rtl/reg_clear_fsm.sv | 67 ++++++
 rtl/reg_bank16.sv | 93 +++++++++
 tb/tb_reg_bank16.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants, clear-FSM state encoding and flattened-bus slot helper
// for the 16-entry register bank and its downstream read mux.
package reg_bank_pkg;

  localparam int DW    = 32;
  localparam int NREGS = 16;
  localparam int AW    = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Slot i of the flattened register view occupies bits [DW*i +: DW].
  function automatic int slot_lsb(input int idx);
    return DW * idx;
  endfunction

endpackage

// File: rtl/reg_clear_fsm.sv
// Bulk-clear sequencer: IDLE/CLEAR state, sweep counter, handshake ready and
// the completion pulse.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | normal operation, write-back accepted, waiting for clr_req
//   CLEAR | sweeping one register per cycle to zero, writes blocked
module reg_clear_fsm
  import reg_bank_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_done,
  output logic          wb_ready,
  output logic          clr_start,
  output logic          sweep_en,
  output logic [AW-1:0] sweep_idx
);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // Requests arriving mid-sweep are ignored; the sweep always completes.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(NREGS - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  assign busy      = (state_q == CLEAR);
  assign wb_ready  = (state_q == IDLE);
  assign clr_start = (state_q == IDLE) && clr_req;
  assign sweep_en  = (state_q == CLEAR);
  assign sweep_idx = cnt_q;
  assign clr_done  = done_q;

endmodule

// File: rtl/reg_bank16.sv
// 16 x 32-bit register bank with one-deep commit latch, bypassed flat view
// and bulk clear. Define REG_BANK_ZERO_REG_EN to hardwire register 0 to zero.
module reg_bank16
  import reg_bank_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic [AW-1:0]       wb_addr,
  input  logic [DW-1:0]       wb_data,
  input  logic                clr_req,
  output logic                busy,
  output logic                clr_done,
  output logic [NREGS*DW-1:0] regs_flat
);

  logic [DW-1:0] arr_q [NREGS];
  logic          pend_valid_q;
  logic [AW-1:0] pend_addr_q;
  logic [DW-1:0] pend_data_q;

  logic          clr_start;
  logic          sweep_en;
  logic [AW-1:0] sweep_idx;
  logic          wb_accept;
  logic          pend_load;

  reg_clear_fsm u_clear_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_req   (clr_req),
    .busy      (busy),
    .clr_done  (clr_done),
    .wb_ready  (wb_ready),
    .clr_start (clr_start),
    .sweep_en  (sweep_en),
    .sweep_idx (sweep_idx)
  );

  assign wb_accept = wb_valid && wb_ready;

  // A write landing on the same edge as the clear start is dropped.
`ifdef REG_BANK_ZERO_REG_EN
  assign pend_load = wb_accept && !clr_start && (wb_addr != '0);
`else
  assign pend_load = wb_accept && !clr_start;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
    end else begin
      pend_valid_q <= pend_load;
      if (pend_load) begin
        pend_addr_q <= wb_addr;
        pend_data_q <= wb_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        arr_q[i] <= '0;
      end
    end else begin
      if (pend_valid_q) begin
        arr_q[pend_addr_q] <= pend_data_q;
      end
      if (sweep_en) begin
        arr_q[sweep_idx] <= '0;
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (pend_valid_q && (pend_addr_q == AW'(i))) begin
        regs_flat[slot_lsb(i) +: DW] = pend_data_q;
      end else begin
        regs_flat[slot_lsb(i) +: DW] = arr_q[i];
      end
    end
`ifdef REG_BANK_ZERO_REG_EN
    regs_flat[slot_lsb(0) +: DW] = '0;
`endif
  end

endmodule

// File: tb/tb_reg_bank16.sv
// Self-checking bench for reg_bank16: directed vector table, hand-written clear
// and reset sequences, and randomized traffic against a register-view model.
module tb_reg_bank16;
  import reg_bank_pkg::*;

  logic                clk;
  logic                rst_n;
  logic                wb_valid;
  logic                wb_ready;
  logic [AW-1:0]       wb_addr;
  logic [DW-1:0]       wb_data;
  logic                clr_req;
  logic                busy;
  logic                clr_done;
  logic [NREGS*DW-1:0] regs_flat;

  reg_bank16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .clr_req   (clr_req),
    .busy      (busy),
    .clr_done  (clr_done),
    .regs_flat (regs_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: what the read mux should see for each register, plus how many
  // sweep edges remain in an active clear.
  logic [DW-1:0] exp_r [NREGS];
  int            clr_left;
  bit            exp_done;

  typedef struct {
    bit            v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            c;
    int            ca;
    logic [DW-1:0] cv;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [DW-1:0] slot(input int i);
    return regs_flat[DW*i +: DW];
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) exp_r[i] = '0;
    clr_left = 0;
    exp_done = 1'b0;
  endtask

  task automatic model_edge();
    if (clr_left > 0) begin
      exp_r[NREGS - clr_left] = '0;
      clr_left--;
      exp_done = (clr_left == 0);
    end else begin
      exp_done = 1'b0;
      if (clr_req) begin
        clr_left = NREGS;
      end else if (wb_valid) begin
`ifdef REG_BANK_ZERO_REG_EN
        if (wb_addr != '0) exp_r[wb_addr] = wb_data;
`else
        exp_r[wb_addr] = wb_data;
`endif
      end
    end
  endtask

  task automatic check_all();
    int bad;
    check("busy", DW'(busy), DW'(clr_left > 0));
    check("wb_ready", DW'(wb_ready), DW'(clr_left == 0));
    check("clr_done", DW'(clr_done), DW'(exp_done));
    bad = -1;
    for (int i = 0; i < NREGS; i++) begin
      if (bad < 0 && slot(i) !== exp_r[i]) bad = i;
    end
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL regs_flat slot %0d: got %h expected %h at %0t", bad, slot(bad), exp_r[bad], $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    clr_req  = 1'b0;
  endtask

  task automatic fill_all();
    for (int i = 0; i < NREGS; i++) begin
      wb_valid = 1'b1;
      wb_addr  = AW'(i);
      wb_data  = 32'h0101_0101 * (i + 1);
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    int busy_n;
    int nready_n;
    int done_n;

    rst_n = 1'b1;
    idle_inputs();
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vector table: one edge per record, one named slot checked.
    tbl[0] = '{1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 5, 32'hDEADBEEF};
    tbl[1] = '{1'b0, 4'd0, 32'h0,        1'b0, 5, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 4'd0, 32'h0,        1'b0, 4, 32'h0};
    tbl[3] = '{1'b1, 4'd3, 32'h11111111, 1'b0, 3, 32'h11111111};
    tbl[4] = '{1'b1, 4'd3, 32'h22222222, 1'b0, 3, 32'h22222222};
    tbl[5] = '{1'b0, 4'd0, 32'h0,        1'b0, 3, 32'h22222222};
    tbl[6] = '{1'b0, 4'd0, 32'h0,        1'b0, 3, 32'h22222222};
`ifdef REG_BANK_ZERO_REG_EN
    tbl[7] = '{1'b1, 4'd0, 32'hFFFFFFFF, 1'b0, 0, 32'h0};
    tbl[8] = '{1'b0, 4'd0, 32'h0,        1'b0, 0, 32'h0};
`else
    tbl[7] = '{1'b1, 4'd0, 32'hFFFFFFFF, 1'b0, 0, 32'hFFFFFFFF};
    tbl[8] = '{1'b0, 4'd0, 32'h0,        1'b0, 0, 32'hFFFFFFFF};
`endif
    for (int k = 0; k < 9; k++) begin
      wb_valid = tbl[k].v;
      wb_addr  = tbl[k].a;
      wb_data  = tbl[k].d;
      clr_req  = tbl[k].c;
      tick();
      check($sformatf("tbl[%0d] slot %0d", k, tbl[k].ca), slot(tbl[k].ca), tbl[k].cv);
    end
    idle_inputs();

    // Full fill then bulk clear, with a stray clr_req mid-sweep.
    fill_all();
    clr_req = 1'b1;
    tick();
    clr_req  = 1'b0;
    busy_n   = busy ? 1 : 0;
    nready_n = wb_ready ? 0 : 1;
    done_n   = 0;
    for (int j = 1; j <= 20; j++) begin
      clr_req = (j == 5);
      tick();
      if (busy) busy_n++;
      if (!wb_ready) nready_n++;
      if (clr_done) done_n++;
      if (j <= NREGS) check($sformatf("sweep slot %0d zero", j - 1), slot(j - 1), '0);
    end
    clr_req = 1'b0;
    check("busy cycles", DW'(busy_n), DW'(NREGS));
    check("not-ready cycles", DW'(nready_n), DW'(NREGS));
    check("clr_done pulses", DW'(done_n), 32'd1);
    check("ready after clear", DW'(wb_ready), 32'd1);

    // Write on the edge before clr_req commits; write on the clr_req edge is dropped.
    wb_valid = 1'b1; wb_addr = 4'd9; wb_data = 32'h12345678;
    tick();
    wb_addr = 4'd7; wb_data = 32'hA5A5A5A5; clr_req = 1'b1;
    tick();
    idle_inputs();
    check("pre-clear write slot 9", slot(9), 32'h12345678);
    check("dropped write slot 7", slot(7), '0);
    repeat (17) tick();
    check("slot 7 after sweep", slot(7), '0);

    // Reset in the middle of a sweep.
    fill_all();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (3) begin
      @(posedge clk);
      #1;
      check("no clr_done in reset", DW'(clr_done), '0);
    end
    rst_n = 1'b1;
    wb_valid = 1'b1; wb_addr = 4'd2; wb_data = 32'hCAFEF00D;
    check("ready after reset", DW'(wb_ready), 32'd1);
    tick();
    idle_inputs();
    tick();
    check("post-reset write slot 2", slot(2), 32'hCAFEF00D);

    // Randomized traffic, including clr_req at arbitrary times.
    for (int n = 0; n < 400; n++) begin
      wb_valid = ($urandom_range(0, 9) < 7);
      wb_addr  = AW'($urandom_range(0, NREGS - 1));
      wb_data  = $urandom();
      clr_req  = ($urandom_range(0, 39) == 0);
      tick();
    end
    idle_inputs();
    repeat (NREGS + 2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
